// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dram_pkg
// Brief    : Shared widths, FSM state encoding and request/response records
//            for the DRAM read scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package dram_pkg;

    localparam int DEF_ROW_W  = 4;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_ROW_W-1:0] row;
    } req_t;

    typedef struct packed {
        logic [DEF_ROW_W-1:0]  row;
        logic [DEF_DATA_W-1:0] content;
    } resp_t;

endpackage
`default_nettype wire

// File: rtl/dram_read_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : dram_read_scheduler_if
// Brief     : Request, DRAM-side and response channels of the scheduler.
// Revision  : 1.0 - initial release
// ============================================================================
interface dram_read_scheduler_if
    import dram_pkg::*;
#(
    parameter int ROW_W  = DEF_ROW_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req_valid;
    logic [ROW_W-1:0]  req_row;
    logic              req_ready;

    logic [ROW_W-1:0]  dram_row;
    logic              dram_input_valid;
    logic [DATA_W-1:0] dram_content;
    logic              dram_output_valid;

    logic              resp_valid;
    logic [ROW_W-1:0]  resp_row;
    logic [DATA_W-1:0] resp_content;

    modport slave (
        input  req_valid, req_row, dram_content, dram_output_valid,
        output req_ready, dram_row, dram_input_valid,
        output resp_valid, resp_row, resp_content
    );

    modport master (
        output req_valid, req_row, dram_content, dram_output_valid,
        input  req_ready, dram_row, dram_input_valid,
        input  resp_valid, resp_row, resp_content
    );

endinterface
`default_nettype wire

// File: rtl/dram_read_scheduler_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : req_fifo
// Brief    : Circular request buffer; pointers carry an extra wrap bit so
//            full and empty are distinguished without a separate counter.
// Revision : 1.0 - initial release
// ============================================================================
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int           c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push_acc;
    logic             w_pop_acc;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_count    = r_wr_ptr - r_rd_ptr;
    assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    // A push while full is dropped; push and pop together are both honoured.
    assign w_push_acc = i_push && !o_full;
    assign w_pop_acc  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/dram_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dram_read_scheduler
// Brief    : Queues row-read requests and issues them one at a time to the
//            DRAM row-read block, tracking row hits and response timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module dram_read_scheduler
    import dram_pkg::*;
#(
    parameter int ROW_W   = DEF_ROW_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dram_read_scheduler_if.slave bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt,
    output logic                 err_timeout
);

    localparam int                   c_AW        = $clog2(DEPTH);
    localparam int                   c_TIMER_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = {{(c_TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_next;
    logic [ROW_W-1:0]    r_dram_row, w_dram_row_next;
    logic                r_issue, w_issue_next;
    logic                r_resp_valid, w_resp_valid_next;
    logic [ROW_W-1:0]    r_resp_row, w_resp_row_next;
    logic [DATA_W-1:0]   r_resp_content, w_resp_content_next;
    logic [c_TIMER_W-1:0] r_timer, w_timer_next;
    logic [CNT_W-1:0]    r_hit, w_hit_next;
    logic [CNT_W-1:0]    r_miss, w_miss_next;
    logic [ROW_W-1:0]    r_last_row, w_last_row_next;
    logic                r_last_valid, w_last_valid_next;
    logic                r_err, w_err_next;
    logic                r_busy, w_busy_next;

    logic                w_pop;
    logic [ROW_W-1:0]    w_pop_data;
    logic                w_full;
    logic                w_empty;
    logic [c_AW:0]       w_count;
    logic [c_AW:0]       w_count_next;
    logic                w_push_acc;

    req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ROW_W)
    ) u_req_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (bus.req_valid),
        .i_push_data (bus.req_row),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign w_push_acc   = bus.req_valid && !w_full;
    assign w_count_next = w_count + {{c_AW{1'b0}}, w_push_acc} - {{c_AW{1'b0}}, w_pop};

    always_comb begin
        w_state_next        = r_state;
        w_pop               = 1'b0;
        w_dram_row_next     = r_dram_row;
        w_issue_next        = 1'b0;
        w_resp_valid_next   = 1'b0;
        w_resp_row_next     = r_resp_row;
        w_resp_content_next = r_resp_content;
        w_timer_next        = r_timer;
        w_hit_next          = r_hit;
        w_miss_next         = r_miss;
        w_last_row_next     = r_last_row;
        w_last_valid_next   = r_last_valid;
        w_err_next          = r_err;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_dram_row_next = w_pop_data;
                    w_state_next    = ISSUE;
                end
            end
            ISSUE: begin
                w_issue_next = 1'b1;
                if (r_last_valid && (r_last_row == r_dram_row)) begin
                    if (!(&r_hit)) w_hit_next = r_hit + c_CNT_ONE;
                end else begin
                    if (!(&r_miss)) w_miss_next = r_miss + c_CNT_ONE;
                end
                w_last_row_next   = r_dram_row;
                w_last_valid_next = 1'b1;
                w_timer_next      = '0;
                w_state_next      = WAIT;
            end
            WAIT: begin
                w_timer_next = r_timer + c_TIMER_ONE;
                // A response on the final timer cycle still counts as a response.
                if (bus.dram_output_valid) begin
                    w_resp_valid_next   = 1'b1;
                    w_resp_row_next     = r_dram_row;
                    w_resp_content_next = bus.dram_content;
                    w_state_next        = IDLE;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_err_next   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        w_busy_next = (w_state_next != IDLE) || (w_count_next != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_dram_row     <= '0;
            r_issue        <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_row     <= '0;
            r_resp_content <= '0;
            r_timer        <= '0;
            r_hit          <= '0;
            r_miss         <= '0;
            r_last_row     <= '0;
            r_last_valid   <= 1'b0;
            r_err          <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_dram_row     <= w_dram_row_next;
            r_issue        <= w_issue_next;
            r_resp_valid   <= w_resp_valid_next;
            r_resp_row     <= w_resp_row_next;
            r_resp_content <= w_resp_content_next;
            r_timer        <= w_timer_next;
            r_hit          <= w_hit_next;
            r_miss         <= w_miss_next;
            r_last_row     <= w_last_row_next;
            r_last_valid   <= w_last_valid_next;
            r_err          <= w_err_next;
            r_busy         <= w_busy_next;
        end
    end

    assign bus.req_ready        = !w_full;
    assign bus.dram_row         = r_dram_row;
    assign bus.dram_input_valid = r_issue;
    assign bus.resp_valid       = r_resp_valid;
    assign bus.resp_row         = r_resp_row;
    assign bus.resp_content     = r_resp_content;
    assign busy                 = r_busy;
    assign hit_cnt              = r_hit;
    assign miss_cnt             = r_miss;
    assign err_timeout          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_read_scheduler
// Brief    : Directed self-checking bench with a small responding DRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_read_scheduler;

    localparam int ROW_W   = 4;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic             err_timeout;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        model_on      = 1'b0;
    int          model_delay   = 1;
    logic [31:0] model_base    = '0;
    logic        model_add_row = 1'b0;
    logic        model_strobe  = 1'b0;
    logic [31:0] model_content = '0;
    logic        manual_strobe = 1'b0;
    logic [31:0] manual_content = '0;

    logic [ROW_W-1:0]  issue_q[$];
    logic [ROW_W-1:0]  resp_row_q[$];
    logic [DATA_W-1:0] resp_data_q[$];

    dram_read_scheduler_if #(.ROW_W(ROW_W), .DATA_W(DATA_W)) bus ();

    assign bus.dram_output_valid = model_strobe | manual_strobe;
    assign bus.dram_content      = manual_strobe ? manual_content : model_content;

    dram_read_scheduler #(
        .ROW_W(ROW_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Record every issue pulse and response pulse seen at the falling edge.
    always @(negedge clk) begin
        if (bus.dram_input_valid) issue_q.push_back(bus.dram_row);
        if (bus.resp_valid) begin
            resp_row_q.push_back(bus.resp_row);
            resp_data_q.push_back(bus.resp_content);
        end
    end

    // DRAM model: answers model_delay edges after the issue edge.
    initial begin : p_model
        logic [ROW_W-1:0] row;
        forever begin
            @(negedge clk);
            if (model_on && bus.dram_input_valid) begin
                row = bus.dram_row;
                repeat (model_delay - 1) @(negedge clk);
                model_content = model_add_row ? (model_base + {28'd0, row}) : model_base;
                model_strobe  = 1'b1;
                @(negedge clk);
                model_strobe  = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish before 100000 time units");
        $fatal(1);
    end

    task automatic apply_reset();
        model_on      = 1'b0;
        manual_strobe = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_row   = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_resps(input int want, input int limit);
        int t = 0;
        while (resp_row_q.size() < want && t < limit) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (resp_row_q.size() < want) begin
            n_fail++;
            $display("FAIL wait_resps: got %0d responses want %0d", resp_row_q.size(), want);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.dram_input_valid !== 1'b0) begin n_fail++; $display("FAIL rst_issue: got %b want 0", bus.dram_input_valid); end
        n_cmp++; if (bus.dram_row !== 4'd0) begin n_fail++; $display("FAIL rst_dram_row: got %h want 0", bus.dram_row); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_content !== 32'd0) begin n_fail++; $display("FAIL rst_resp_content: got %h want 0", bus.resp_content); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    endtask

    task automatic test_single();
        int i0, r0;
        apply_reset();
        i0 = issue_q.size(); r0 = resp_row_q.size();
        model_on = 1'b1; model_delay = 4; model_base = 32'hDEADBEEF; model_add_row = 1'b0;
        bus.req_valid = 1'b1; bus.req_row = 4'd2;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.dram_input_valid !== 1'b0) begin n_fail++; $display("FAIL single_issue_e1: got %b want 0", bus.dram_input_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (bus.dram_input_valid !== 1'b0) begin n_fail++; $display("FAIL single_issue_e2: got %b want 0", bus.dram_input_valid); end
        @(negedge clk);
        n_cmp++; if (bus.dram_input_valid !== 1'b1 || bus.dram_row !== 4'd2) begin n_fail++; $display("FAIL single_issue_e3: got %b row %h want 1 row 2", bus.dram_input_valid, bus.dram_row); end
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_row !== 4'd2) begin n_fail++; $display("FAIL single_resp: got %b row %h want 1 row 2", bus.resp_valid, bus.resp_row); end
        n_cmp++; if (bus.resp_content !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_content: got %h want deadbeef", bus.resp_content); end
        @(negedge clk);
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_resp_pulse: got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.dram_row !== 4'd2) begin n_fail++; $display("FAIL single_row_hold: got %h want 2", bus.dram_row); end
        repeat (3) @(negedge clk);
        n_cmp++; if (issue_q.size() - i0 != 1 || resp_row_q.size() - r0 != 1) begin n_fail++; $display("FAIL single_counts: got %0d issues %0d resps want 1 1", issue_q.size() - i0, resp_row_q.size() - r0); end
        n_cmp++; if (miss_cnt !== 8'd1 || hit_cnt !== 8'd0) begin n_fail++; $display("FAIL single_stats: got miss %0d hit %0d want 1 0", miss_cnt, hit_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_row_hits();
        int i0, r0;
        logic [3:0]  exp_rows [4] = '{4'd9, 4'd9, 4'd9, 4'd15};
        logic [31:0] exp_data [4] = '{32'h10000009, 32'h10000009, 32'h10000009, 32'h1000000F};
        apply_reset();
        i0 = issue_q.size(); r0 = resp_row_q.size();
        model_on = 1'b1; model_delay = 2; model_base = 32'h10000000; model_add_row = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 1'b1; bus.req_row = exp_rows[k];
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        wait_resps(r0 + 4, 200);
        repeat (4) @(negedge clk);
        n_cmp++; if (issue_q.size() - i0 != 4 || resp_row_q.size() - r0 != 4) begin n_fail++; $display("FAIL hits_counts: got %0d issues %0d resps want 4 4", issue_q.size() - i0, resp_row_q.size() - r0); end
        for (int k = 0; k < 4; k++) begin
            if (i0 + k < issue_q.size()) begin
                n_cmp++; if (issue_q[i0 + k] !== exp_rows[k]) begin n_fail++; $display("FAIL hits_issue_row[%0d]: got %h want %h", k, issue_q[i0 + k], exp_rows[k]); end
            end
            if (r0 + k < resp_row_q.size()) begin
                n_cmp++; if (resp_row_q[r0 + k] !== exp_rows[k] || resp_data_q[r0 + k] !== exp_data[k]) begin n_fail++; $display("FAIL hits_resp[%0d]: got %h/%h want %h/%h", k, resp_row_q[r0 + k], resp_data_q[r0 + k], exp_rows[k], exp_data[k]); end
            end
        end
        n_cmp++; if (hit_cnt !== 8'd2 || miss_cnt !== 8'd2) begin n_fail++; $display("FAIL hits_stats: got hit %0d miss %0d want 2 2", hit_cnt, miss_cnt); end
    endtask

    task automatic test_fifo_full();
        int i0, r0;
        apply_reset();
        i0 = issue_q.size(); r0 = resp_row_q.size();
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (bus.req_ready !== (k < 5)) begin n_fail++; $display("FAIL full_ready[%0d]: got %b want %b", k, bus.req_ready, (k < 5)); end
            bus.req_valid = 1'b1; bus.req_row = 4'(k + 1);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_hold: got %b want 0", bus.req_ready); end
        manual_content = 32'hF0000001; manual_strobe = 1'b1;
        @(negedge clk);
        manual_strobe = 1'b0;
        model_on = 1'b1; model_delay = 1; model_base = 32'hF0000000; model_add_row = 1'b1;
        wait_resps(r0 + 5, 300);
        repeat (20) @(negedge clk);
        n_cmp++; if (resp_row_q.size() - r0 != 5 || issue_q.size() - i0 != 5) begin n_fail++; $display("FAIL full_counts: got %0d resps %0d issues want 5 5", resp_row_q.size() - r0, issue_q.size() - i0); end
        for (int k = 0; k < 5; k++) begin
            if (r0 + k < resp_row_q.size()) begin
                n_cmp++; if (resp_row_q[r0 + k] !== 4'(k + 1) || resp_data_q[r0 + k] !== 32'hF0000000 + 32'(k + 1)) begin n_fail++; $display("FAIL full_resp[%0d]: got %h/%h want %h/%h", k, resp_row_q[r0 + k], resp_data_q[r0 + k], k + 1, 32'hF0000000 + 32'(k + 1)); end
            end
        end
        n_cmp++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL full_drain: got ready %b busy %b want 1 0", bus.req_ready, busy); end
    endtask

    task automatic test_timeout();
        int i0, r0;
        apply_reset();
        i0 = issue_q.size(); r0 = resp_row_q.size();
        bus.req_valid = 1'b1; bus.req_row = 4'd3;
        @(negedge clk);
        bus.req_row = 4'd4;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (16) @(negedge clk);
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", err_timeout); end
        @(negedge clk);
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", err_timeout); end
        n_cmp++; if (resp_row_q.size() - r0 != 0) begin n_fail++; $display("FAIL tmo_no_resp: got %0d resps want 0", resp_row_q.size() - r0); end
        manual_content = 32'hBAD0BAD0; manual_strobe = 1'b1;
        @(negedge clk);
        manual_strobe = 1'b0;
        model_on = 1'b1; model_delay = 2; model_base = 32'h40000000; model_add_row = 1'b1;
        wait_resps(r0 + 1, 100);
        model_on = 1'b0;
        repeat (3) @(negedge clk);
        manual_strobe = 1'b1;
        @(negedge clk);
        manual_strobe = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (resp_row_q.size() - r0 != 1 || issue_q.size() - i0 != 2) begin n_fail++; $display("FAIL tmo_counts: got %0d resps %0d issues want 1 2", resp_row_q.size() - r0, issue_q.size() - i0); end
        if (resp_row_q.size() > r0) begin
            n_cmp++; if (resp_row_q[r0] !== 4'd4 || resp_data_q[r0] !== 32'h40000004) begin n_fail++; $display("FAIL tmo_next_resp: got %h/%h want 4/40000004", resp_row_q[r0], resp_data_q[r0]); end
        end
        n_cmp++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_simultaneous();
        int r0;
        apply_reset();
        r0 = resp_row_q.size();
        model_on = 1'b1; model_delay = 16; model_base = 32'h55000000; model_add_row = 1'b1;
        bus.req_valid = 1'b1; bus.req_row = 4'd5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_resps(r0 + 1, 100);
        repeat (3) @(negedge clk);
        n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL simul_err: got %b want 0", err_timeout); end
        if (resp_row_q.size() > r0) begin
            n_cmp++; if (resp_row_q[r0] !== 4'd5 || resp_data_q[r0] !== 32'h55000005) begin n_fail++; $display("FAIL simul_resp: got %h/%h want 5/55000005", resp_row_q[r0], resp_data_q[r0]); end
        end
    endtask

    task automatic test_reset_mid();
        int i1, r1;
        apply_reset();
        model_on = 1'b1; model_delay = 1; model_base = 32'h77000000; model_add_row = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 1'b1; bus.req_row = 4'(7 + k);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        model_on = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || bus.resp_content !== 32'h77000007) begin n_fail++; $display("FAIL mid_pre: got busy %b content %h want 1 77000007", busy, bus.resp_content); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.dram_row !== 4'd0 || bus.dram_input_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_row !== 4'd0) begin n_fail++; $display("FAIL mid_async_ctl: got row %h iv %b rv %b rrow %h want 0 0 0 0", bus.dram_row, bus.dram_input_valid, bus.resp_valid, bus.resp_row); end
        n_cmp++; if (bus.resp_content !== 32'd0 || busy !== 1'b0 || hit_cnt !== 8'd0 || miss_cnt !== 8'd0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL mid_async_stat: got %h %b %0d %0d %b want 0 0 0 0 0", bus.resp_content, busy, hit_cnt, miss_cnt, err_timeout); end
        i1 = issue_q.size(); r1 = resp_row_q.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_release: got ready %b busy %b want 1 0", bus.req_ready, busy); end
        model_on = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (issue_q.size() != i1 || resp_row_q.size() != r1) begin n_fail++; $display("FAIL mid_quiet: got %0d issues %0d resps want 0 0", issue_q.size() - i1, resp_row_q.size() - r1); end
        model_on = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_row   = '0;
        test_reset();
        test_single();
        test_row_hits();
        test_fifo_full();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
